dcache_wb_buffer: RTL and testbench
===================================

# dcache_wb_buffer

Single-entry write buffer between the data cache / uncached store path and the AXI write channels of the SRAM-AXI bridge. It accepts one write request per transaction, either a 16-byte dirty-line writeback or a single uncached store. It drives it out as one AXI write burst (AW, then W beats, then B), and releases `wr_rdy` only after the B response. A combinational address check lets the read-refill path stall any read that targets the line still in flight.

## Interface
Parameters:
- `AXI_ID`, default 4'd1: value driven on `awid` and `wid`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wr_req` in 1: write request from dcache or uncached store path.
- `wr_type` in 3: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line.
- `wr_addr` in 32: physical address.
- `wr_wstrb` in 4: byte strobes; ignored for line type.
- `wr_data` in 128: line data. Word 0 is `[31:0]`; a single store uses `[31:0]` only.
- `wr_rdy` out 1: buffer empty, request accepted on `wr_req & wr_rdy`.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awlock` out 2, `awcache` out 4, `awprot` out 3, `awvalid` out 1, `awready` in 1: AXI write address channel.
- `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1: AXI write data channel.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write response channel.
- `chk_addr` in 32: address of a pending read (refill or uncached load).
- `chk_hit` out 1: pending read conflicts with the buffered write.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
  - IDLE → ADDR on `wr_req & wr_rdy`. All request fields are captured into the buffer registers.
  - ADDR → DATA on `awvalid & awready`.
  - DATA → RESP on `wvalid & wready & wlast`.
  - RESP → IDLE on `bvalid & bready`.
- `wr_rdy` = (state == IDLE). `awvalid` = ADDR, `wvalid` = DATA, `bready` = RESP.
- Line type (3'b100):
  - `awaddr` = {buf_addr[31:4], 4'b0}, `awlen` = 8'd3, `awsize` = 3'd2, `awburst` = 2'b01.
  - `wstrb` = 4'hf.
  - A 2-bit beat counter selects `wdata` = buf_data[32*cnt +: 32]. The counter is cleared on entry to DATA and increments on each W handshake.
  - `wlast` = (cnt == 2'd3).
- Single store (3'b000/001/010):
  - `awaddr` = buf_addr, `awlen` = 8'd0, `awsize` = {1'b0, buf_type[1:0]}, `awburst` = 2'b01.
  - `wdata` = buf_data[31:0], `wstrb` = buf_wstrb, `wlast` = 1.
- Other `wr_type` encodings are accepted and treated as a word store.
- Constants: `awid` = `wid` = AXI_ID; `awlock`, `awcache`, `awprot` = 0.
- `bid` and `bresp` are ignored; any response completes the transaction.
- `chk_hit` = (state != IDLE) & (chk_addr[31:4] == buf_addr[31:4]). It is combinational and line-granular for both write types.
- Signals held stable while valid is asserted and not yet handshaken: `awaddr`/`awlen`/`awsize` in ADDR, and `wdata`/`wstrb`/`wlast` in DATA.

## Timing
- Reset: state IDLE, beat counter 0, buffer registers 0. Outputs after reset: `wr_rdy` = 1, `awvalid` = `wvalid` = `bready` = 0, `chk_hit` = 0.
- Reset asserted in any state abandons the transaction. The next cycle is IDLE with all valids low and no partial burst resumed.
- Zero-wait line writeback:
  - Request accepted in cycle 0.
  - AW handshake in cycle 1.
  - W beats in cycles 2–5, with `wlast` in cycle 5.
  - B in cycle 6.
  - `wr_rdy` = 1 in cycle 7.
- Zero-wait single store: accept in cycle 0, AW in 1, W in 2, B in 3, `wr_rdy` in 4.
- Each handshake costs at least one cycle. Ready stalls extend the current state indefinitely with outputs frozen.
- AW and W are never valid in the same cycle. `bvalid` outside RESP is ignored (`bready` = 0).
- No new request is accepted in the cycle RESP completes; the earliest next acceptance is the following IDLE cycle.
- `chk_hit` rises in the cycle after acceptance and falls in the cycle after the B handshake.

## Test plan
- Line writeback: `wr_addr` = 0x1C001238, data words 0x11111111/22222222/33333333/44444444, all readies high. Required:
  - `awaddr` = 0x1C001230, `awlen` = 3.
  - W beats in order 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `wstrb` = f.
  - `wlast` only on the 4th beat.
  - `wr_rdy` returns high 7 cycles after acceptance.
- Uncached byte store: type 000, addr 0xBFAF8003, `wstrb` = 4'b1000, data 0xAB000000. Required: `awsize` = 0, `awlen` = 0, one W beat with `wstrb` 1000 and `wlast` = 1.
- Backpressure: `awready` low for 3 cycles, then `wready` toggling every other cycle. Required:
  - `awaddr` stable while `awvalid` is high.
  - No beat skipped or repeated: 4 distinct beats total.
  - `wr_rdy` low throughout.
- Conflict check during a line write to 0x1C001230:
  - `chk_addr` = 0x1C00123C → `chk_hit` = 1.
  - `chk_addr` = 0x1C001240 → `chk_hit` = 0.
  - After B, `chk_hit` = 0 for both.
- Reset during DATA after 2 beats. Required: the next cycle has `wvalid` = 0 and `wr_rdy` = 1. A new single store then completes normally with `awlen` = 0.

Source files
------------

// File: rtl/dcache_wb_buffer.sv
// Single-entry write buffer: holds one dcache line writeback or one uncached
// store and plays it out as a single AXI write burst (AW, W beats, B).
//
// state  | meaning
// IDLE   | buffer empty, wr_rdy high, accepts a request
// ADDR   | awvalid high, waiting for awready
// DATA   | wvalid high, beat counter selects the current word
// RESP   | bready high, waiting for bvalid
module dcache_wb_buffer #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  input  logic [31:0]  chk_addr,
  output logic         chk_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t         r_state;
  logic [1:0]     r_cnt;
  logic [2:0]     r_type;
  logic [31:0]    r_addr;
  logic [3:0]     r_wstrb;
  logic [127:0]   r_data;

  logic           w_line;
  logic           w_wlast;
  logic [2:0]     w_type_norm;
  logic           w_unused;

  // Unrecognised encodings are stored as a word store so the AXI side only
  // ever sees the four legal kinds.
  always_comb begin
    w_type_norm = 3'b010;
    case (wr_type)
      3'b000, 3'b001, 3'b010, 3'b100: w_type_norm = wr_type;
      default:                        w_type_norm = 3'b010;
    endcase
  end

  assign w_line  = (r_type == 3'b100);
  assign w_wlast = w_line ? (r_cnt == 2'd3) : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_type  <= 3'd0;
      r_addr  <= 32'd0;
      r_wstrb <= 4'd0;
      r_data  <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wr_req) begin
            r_type  <= w_type_norm;
            r_addr  <= wr_addr;
            r_wstrb <= wr_wstrb;
            r_data  <= wr_data;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (awready) begin
            r_cnt   <= 2'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wready) begin
            if (w_wlast) r_state <= S_RESP;
            else         r_cnt   <= r_cnt + 2'd1;
          end
        end
        S_RESP: begin
          if (bvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_rdy  = (r_state == S_IDLE);
  assign awvalid = (r_state == S_ADDR);
  assign wvalid  = (r_state == S_DATA);
  assign bready  = (r_state == S_RESP);

  assign awid    = AXI_ID;
  assign awaddr  = w_line ? {r_addr[31:4], 4'b0000} : r_addr;
  assign awlen   = w_line ? 8'd3 : 8'd0;
  assign awsize  = w_line ? 3'd2 : {1'b0, r_type[1:0]};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = w_line ? r_data[{r_cnt, 5'b00000} +: 32] : r_data[31:0];
  assign wstrb   = w_line ? 4'hf : r_wstrb;
  assign wlast   = w_wlast;

  // Line-granular for both write types so a refill never races a store.
  assign chk_hit = (r_state != S_IDLE) && (chk_addr[31:4] == r_addr[31:4]);

  // Any B response completes the write; ID and response code are not used.
  assign w_unused = ^{bid, bresp, chk_addr[3:0]};

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: line writeback, byte store,
// AW/W backpressure, conflict check and reset in the middle of a burst.
module tb_dcache_wb_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  chk_addr;
  logic         chk_hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_wb_buffer #(.AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] line_w [4];
  logic [31:0] aw_hold;
  int          beats;
  int          cyc;
  logic        wr_tgl;

  initial begin
    line_w[0] = 32'h11111111; line_w[1] = 32'h22222222;
    line_w[2] = 32'h33333333; line_w[3] = 32'h44444444;
    reset = 1'b1; wr_req = 1'b0; wr_type = 3'b000; wr_addr = '0;
    wr_wstrb = '0; wr_data = '0; awready = 1'b1; wready = 1'b1;
    bid = 4'd0; bresp = 2'd0; bvalid = 1'b1; chk_addr = 32'h1C00123C;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state (bvalid already high: must be ignored in IDLE)
    @(negedge clk);
    chk("rst_wr_rdy",  32'(wr_rdy),  32'd1);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid",  32'(wvalid),  32'd0);
    chk("rst_bready",  32'(bready),  32'd0);
    chk("rst_chk_hit", 32'(chk_hit), 32'd0);

    // zero-wait line writeback; cycle 0 = accept
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C001238; wr_wstrb = 4'h0;
    wr_data = {line_w[3], line_w[2], line_w[1], line_w[0]};
    @(negedge clk); // cycle 1
    wr_req = 1'b0;
    chk("line_awvalid", 32'(awvalid), 32'd1);
    chk("line_awaddr",  awaddr, 32'h1C001230);
    chk("line_awlen",   32'(awlen), 32'd3);
    chk("line_awsize",  32'(awsize), 32'd2);
    chk("line_awburst", 32'(awburst), 32'd1);
    chk("line_awid",    32'(awid), 32'd1);
    chk("line_aw_w_excl", 32'(wvalid), 32'd0);
    chk("hit_same_line", 32'(chk_hit), 32'd1);
    chk_addr = 32'h1C001240;
    #1 chk("miss_next_line", 32'(chk_hit), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); // cycles 2..5
      chk($sformatf("line_wvalid%0d", i), 32'(wvalid), 32'd1);
      chk($sformatf("line_wdata%0d", i),  wdata, line_w[i]);
      chk($sformatf("line_wstrb%0d", i),  32'(wstrb), 32'hf);
      chk($sformatf("line_wlast%0d", i),  32'(wlast), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("line_wr_rdy%0d", i), 32'(wr_rdy), 32'd0);
    end
    wr_req = 1'b1; wr_type = 3'b000; // held through RESP: must not be taken there
    @(negedge clk); // cycle 6
    chk("line_bready", 32'(bready), 32'd1);
    chk("line_wvalid_resp", 32'(wvalid), 32'd0);
    wr_req = 1'b0;
    @(negedge clk); // cycle 7
    chk("line_wr_rdy_done", 32'(wr_rdy), 32'd1);
    chk("line_no_accept_in_resp", 32'(awvalid), 32'd0);
    chk("after_b_miss_240", 32'(chk_hit), 32'd0);
    chk_addr = 32'h1C00123C;
    #1 chk("after_b_miss_23c", 32'(chk_hit), 32'd0);

    // uncached byte store
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'hBFAF8003; wr_wstrb = 4'b1000;
    wr_data = {96'd0, 32'hAB000000};
    @(negedge clk);
    wr_req = 1'b0;
    chk("byte_awaddr", awaddr, 32'hBFAF8003);
    chk("byte_awsize", 32'(awsize), 32'd0);
    chk("byte_awlen",  32'(awlen), 32'd0);
    @(negedge clk);
    chk("byte_wvalid", 32'(wvalid), 32'd1);
    chk("byte_wdata",  wdata, 32'hAB000000);
    chk("byte_wstrb",  32'(wstrb), 32'h8);
    chk("byte_wlast",  32'(wlast), 32'd1);
    @(negedge clk);
    chk("byte_bready", 32'(bready), 32'd1);
    @(negedge clk);
    chk("byte_wr_rdy", 32'(wr_rdy), 32'd1);

    // backpressure: awready low 3 cycles, then wready toggling
    awready = 1'b0; wready = 1'b0;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C001238;
    wr_data = {line_w[3], line_w[2], line_w[1], line_w[0]};
    @(negedge clk);
    wr_req = 1'b0;
    aw_hold = awaddr;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_awvalid%0d", i), 32'(awvalid), 32'd1);
      chk($sformatf("bp_awaddr%0d", i), awaddr, 32'h1C001230);
      chk($sformatf("bp_awaddr_stable%0d", i), awaddr, aw_hold);
      chk($sformatf("bp_wr_rdy_aw%0d", i), 32'(wr_rdy), 32'd0);
      @(negedge clk);
    end
    awready = 1'b1;
    chk("bp_awvalid_last", 32'(awvalid), 32'd1);
    @(negedge clk);
    awready = 1'b0;
    beats = 0; cyc = 0; wr_tgl = 1'b0;
    while (!bready && cyc < 20) begin
      wready = wr_tgl;
      wr_tgl = ~wr_tgl;
      chk($sformatf("bp_wr_rdy_w%0d", cyc), 32'(wr_rdy), 32'd0);
      if (wvalid && beats < 4) begin
        chk($sformatf("bp_wdata_c%0d", cyc), wdata, line_w[beats]);
        chk($sformatf("bp_wlast_c%0d", cyc), 32'(wlast), (beats == 3) ? 32'd1 : 32'd0);
        if (wready) beats++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("bp_reached_resp", 32'(bready), 32'd1);
    chk("bp_beat_count", 32'(beats), 32'd4);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    chk("bp_wr_rdy_done", 32'(wr_rdy), 32'd1);

    // reset in DATA after two beats
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00002000;
    @(negedge clk); // AW
    wr_req = 1'b0;
    @(negedge clk); // beat 0
    @(negedge clk); // beat 1
    @(negedge clk); // DATA with two beats done
    chk("rst_mid_wdata", wdata, line_w[2]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_wvalid", 32'(wvalid), 32'd0);
    chk("rst_mid_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("rst_mid_awvalid", 32'(awvalid), 32'd0);

    // single store after reset; unused encoding 3'b111 behaves as a word
    wr_req = 1'b1; wr_type = 3'b111; wr_addr = 32'h00001004; wr_wstrb = 4'hf;
    wr_data = {96'd0, 32'h12345678};
    @(negedge clk);
    wr_req = 1'b0;
    chk("post_awlen",  32'(awlen), 32'd0);
    chk("post_awsize", 32'(awsize), 32'd2);
    chk("post_awaddr", awaddr, 32'h00001004);
    @(negedge clk);
    chk("post_wdata", wdata, 32'h12345678);
    chk("post_wlast", 32'(wlast), 32'd1);
    @(negedge clk);
    chk("post_bready", 32'(bready), 32'd1);
    @(negedge clk);
    chk("post_wr_rdy", 32'(wr_rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
